// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master fetching/storing single bytes in an external serial SRAM/flash.
// Optional write path enabled by defining SPI_MEM_WRITE_EN; otherwise every access is a read.
module spi_mem_ctrl #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] PHASE_LAST = 8'(DIV - 1);

  state_t      state_reg, state_next;
  logic [39:0] frame_reg;
  logic [7:0]  phase_reg;
  logic [5:0]  bit_reg;
  logic        sck_reg;
  logic        we_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  rdata_reg;

  logic        we_eff;
  logic [7:0]  data_byte;
  logic        accept;
  logic        phase_end;
  logic        last_bit;

`ifdef SPI_MEM_WRITE_EN
  assign we_eff    = we;
  assign data_byte = we ? wdata : 8'h00;
`else
  logic unused_write;
  assign unused_write = ^{we, wdata};
  assign we_eff       = 1'b0;
  assign data_byte    = 8'h00;
`endif

  // DONE also accepts a held request so back-to-back frames are 80*DIV+1 cycles apart.
  assign accept    = req && (state_reg == IDLE || state_reg == DONE);
  assign phase_end = (phase_reg == PHASE_LAST);
  assign last_bit  = (state_reg == SHIFT) && phase_end && sck_reg && (bit_reg == 6'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      frame_reg <= 40'h0;
      phase_reg <= 8'h00;
      bit_reg   <= 6'd0;
      sck_reg   <= 1'b0;
      we_reg    <= 1'b0;
      rx_reg    <= 8'h00;
      rdata_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        frame_reg <= {(we_eff ? 8'h02 : 8'h03), 8'h00, addr, data_byte};
        phase_reg <= 8'h00;
        bit_reg   <= 6'd39;
        sck_reg   <= 1'b0;
        we_reg    <= we_eff;
      end else if (state_reg == SHIFT) begin
        if (phase_end) begin
          phase_reg <= 8'h00;
          sck_reg   <= ~sck_reg;
          if (!sck_reg) begin
            // Rising SCK edge: capture slave data; only the last 8 samples survive.
            if (!we_reg) begin
              rx_reg <= {rx_reg[6:0], spi_miso};
            end
          end else if (bit_reg != 6'd0) begin
            bit_reg   <= bit_reg - 6'd1;
            frame_reg <= {frame_reg[38:0], 1'b0};
          end
        end else begin
          phase_reg <= phase_reg + 8'h01;
        end
      end
      if (last_bit && !we_reg) begin
        rdata_reg <= rx_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = req ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      SHIFT: begin
        spi_cs_n = 1'b0;
        spi_sck  = sck_reg;
        spi_mosi = frame_reg[39];
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: three instances (DIV = 1, 3, 255) against a cycle-level SPI slave model.
module tb_spi_mem_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [N];
  logic        we    [N];
  logic [15:0] addr  [N];
  logic [7:0]  wdata [N];
  logic [7:0]  rdata [N];
  logic        busy  [N];
  logic        done  [N];
  logic        cs_n  [N];
  logic        sck   [N];
  logic        mosi  [N];
  logic        miso  [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      spi_mem_ctrl #(.DIV(gi == 0 ? 1 : (gi == 1 ? 3 : 255))) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req[gi]),
        .we      (we[gi]),
        .addr    (addr[gi]),
        .wdata   (wdata[gi]),
        .rdata   (rdata[gi]),
        .busy    (busy[gi]),
        .done    (done[gi]),
        .spi_cs_n(cs_n[gi]),
        .spi_sck (sck[gi]),
        .spi_mosi(mosi[gi]),
        .spi_miso(miso[gi])
      );
    end
  endgenerate

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 255);
  endfunction

  // Slave / bus-monitor state, one slot per instance
  int          nbits [N], run [N], hi_min [N], hi_max [N], lo_min [N], lo_max [N];
  int          last_nbits [N], frames [N], cs_low_len [N], last_cs_low [N];
  int          cs_high_run [N], last_gap [N], fall_cyc [N], last_spacing [N];
  int          done_cnt [N], idle_viol [N];
  logic        cur_lvl [N], prev_cs [N], junk [N];
  logic [39:0] bits [N], last_frame [N];
  logic [7:0]  resp [N], exp_rd [N];
  int          cyc = 0;

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave answers the last 8 bit slots with the response byte, junk elsewhere.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      miso[i] = (nbits[i] >= 32 && nbits[i] < 40) ? resp[i][3'(39 - nbits[i])] : junk[i];
    end
  end

  task automatic record_run(input int i);
    if (cur_lvl[i]) begin
      if (run[i] < hi_min[i]) hi_min[i] = run[i];
      if (run[i] > hi_max[i]) hi_max[i] = run[i];
    end else begin
      if (run[i] < lo_min[i]) lo_min[i] = run[i];
      if (run[i] > lo_max[i]) lo_max[i] = run[i];
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (done[i]) done_cnt[i]++;
      if (!cs_n[i]) begin
        if (prev_cs[i]) begin
          nbits[i] = 0; bits[i] = 40'h0; cur_lvl[i] = sck[i]; run[i] = 1; cs_low_len[i] = 1;
          last_gap[i] = cs_high_run[i]; last_spacing[i] = cyc - fall_cyc[i]; fall_cyc[i] = cyc;
        end else begin
          cs_low_len[i]++;
          if (sck[i] == cur_lvl[i]) run[i]++;
          else begin
            record_run(i);
            if (sck[i]) begin
              bits[i] = {bits[i][38:0], mosi[i]};
              nbits[i]++;
              junk[i] = 1'($urandom);
            end
            cur_lvl[i] = sck[i];
            run[i] = 1;
          end
        end
      end else begin
        if (!prev_cs[i]) begin
          record_run(i);
          last_frame[i] = bits[i]; last_nbits[i] = nbits[i]; last_cs_low[i] = cs_low_len[i];
          frames[i]++; cs_high_run[i] = 1; nbits[i] = 0;
        end else cs_high_run[i]++;
        if (sck[i] || mosi[i]) idle_viol[i]++;
      end
      prev_cs[i] = cs_n[i];
    end
  end

  task automatic clear_stats(input int i);
    hi_min[i] = 1 << 30; hi_max[i] = 0; lo_min[i] = 1 << 30; lo_max[i] = 0;
    done_cnt[i] = 0; idle_viol[i] = 0; frames[i] = 0;
  endtask

  function automatic logic eff_we(input logic w);
`ifdef SPI_MEM_WRITE_EN
    return w;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [39:0] exp_frame(input logic w, input logic [15:0] a, input logic [7:0] d);
    logic e;
    e = eff_we(w);
    return {(e ? 8'h02 : 8'h03), 8'h00, a, (e ? d : 8'h00)};
  endfunction

  task automatic start_txn(input int i, input logic w, input logic [15:0] a,
                           input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    we[i] = w; addr[i] = a; wdata[i] = d; resp[i] = r;
    clear_stats(i);
    req[i] = 1'b1;
    @(posedge clk);
    #1 req[i] = 1'b0;
  endtask

  // Returns cycles from the acceptance edge to the done cycle.
  task automatic wait_done(input int i, input logic [39:0] fr, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 0) begin
        check_eq("busy_after_accept", busy[i], 1'b1);
        check_eq("cs_after_accept", cs_n[i], 1'b0);
        check_eq("mosi_first_bit", mosi[i], fr[39]);
      end
      if (done[i]) break;
      n++;
      if (n > 80 * div_of(i) + 20) break;
    end
  endtask

  task automatic finish_txn(input int i, input logic w, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] r, input int lat);
    int dv;
    dv = div_of(i);
    if (!eff_we(w)) exp_rd[i] = r;
    check_eq("done_latency", lat, 80 * dv);
    check_eq("rdata_at_done", rdata[i], exp_rd[i]);
    @(negedge clk);
    check_eq("busy_after_done", busy[i], 1'b0);
    check_eq("done_pulses", done_cnt[i], 1);
    check_eq("frame_count", frames[i], 1);
    check_eq("frame_bits", last_nbits[i], 40);
    check_eq("mosi_frame", last_frame[i], exp_frame(w, a, d));
    check_eq("cs_low_cycles", last_cs_low[i], 80 * dv);
    check_eq("sck_hi_min", hi_min[i], dv);
    check_eq("sck_hi_max", hi_max[i], dv);
    check_eq("sck_lo_min", lo_min[i], dv);
    check_eq("sck_lo_max", lo_max[i], dv);
    check_eq("idle_pins", idle_viol[i], 0);
    check_eq("rdata_hold", rdata[i], exp_rd[i]);
    $display("txn inst=%0d div=%0d we=%0d addr=%04h wdata=%02h rdata=%02h lat=%0d",
             i, dv, w, a, d, rdata[i], lat);
  endtask

  task automatic run_txn(input int i, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] r);
    int lat;
    start_txn(i, w, a, d, r);
    // Inputs scrambled while busy must not leak into the frame.
    we[i] = 1'($urandom); addr[i] = 16'($urandom); wdata[i] = 8'($urandom);
    wait_done(i, exp_frame(w, a, d), lat);
    finish_txn(i, w, a, d, r, lat);
  endtask

  task automatic wait_frames(input int i, input int target, input int limit);
    int n;
    n = 0;
    while (frames[i] < target && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; wdata[i] = 8'h0; resp[i] = 8'h0;
      exp_rd[i] = 8'h00; prev_cs[i] = 1'b1; cur_lvl[i] = 1'b0; junk[i] = 1'b0;
      nbits[i] = 0; run[i] = 0; bits[i] = 40'h0; cs_high_run[i] = 0; fall_cyc[i] = 0;
      clear_stats(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_eq("rst_cs_n", cs_n[i], 1'b1);
      check_eq("rst_sck", sck[i], 1'b0);
      check_eq("rst_mosi", mosi[i], 1'b0);
      check_eq("rst_busy", busy[i], 1'b0);
      check_eq("rst_done", done[i], 1'b0);
      check_eq("rst_rdata", rdata[i], 8'h00);
    end
    rst_n = 1'b1;

    run_txn(0, 1'b0, 16'h1234, 8'h00, 8'hA5);

    for (int k = 0; k < 8; k++)
      run_txn(0, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));

    run_txn(1, 1'b0, 16'h4321, 8'h00, 8'h77);
    run_txn(1, 1'b1, 16'hFFFF, 8'h5A, 8'hC3);
    for (int k = 0; k < 3; k++)
      run_txn(1, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));

    // Reset in the middle of a read abandons it without a done pulse.
    start_txn(0, 1'b0, 16'h2222, 8'h00, 8'h99);
    for (int n = 0; n < 200 && nbits[0] < 20; n++) @(negedge clk);
    check_eq("abort_at_bit20", nbits[0], 20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_cs_n", cs_n[0], 1'b1);
    check_eq("abort_sck", sck[0], 1'b0);
    check_eq("abort_busy", busy[0], 1'b0);
    check_eq("abort_rdata", rdata[0], 8'h00);
    check_eq("abort_rdata_inst1", rdata[1], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) exp_rd[i] = 8'h00;
    repeat (100) @(negedge clk);
    check_eq("abort_no_done", done_cnt[0], 0);
    run_txn(0, 1'b0, 16'h0001, 8'h00, 8'h6E);

    // A request while busy, with a new address, is ignored.
    start_txn(0, 1'b0, 16'h1357, 8'h00, 8'h3C);
    repeat (10) @(negedge clk);
    addr[0] = 16'hBEEF; req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    wait_done(0, exp_frame(1'b0, 16'h1357, 8'h00), lat);
    lat = lat + 11;
    exp_rd[0] = 8'h3C;
    check_eq("ignored_req_rdata", rdata[0], 8'h3C);
    repeat (120) @(negedge clk);
    check_eq("ignored_req_frames", frames[0], 1);
    check_eq("ignored_req_done", done_cnt[0], 1);
    check_eq("ignored_req_addr", last_frame[0], exp_frame(1'b0, 16'h1357, 8'h00));
    $display("txn inst=0 div=1 we=0 addr=1357 busy-req ignored rdata=%02h lat=%0d", rdata[0], lat);

    // Held request: frames back to back, one cycle of CS high between them.
    @(negedge clk);
    we[0] = 1'b0; addr[0] = 16'h0F0F; resp[0] = 8'h81;
    clear_stats(0);
    req[0] = 1'b1;
    wait_frames(0, 3, 400);
    check_eq("held_frames", frames[0], 3);
    @(negedge clk);
    check_eq("held_spacing", last_spacing[0], 81);
    check_eq("held_cs_gap", last_gap[0], 1);
    req[0] = 1'b0;
    exp_rd[0] = 8'h81;
    repeat (150) @(negedge clk);
    check_eq("held_total_frames", frames[0], 4);
    check_eq("held_done_count", done_cnt[0], 4);
    check_eq("held_rdata", rdata[0], 8'h81);
    check_eq("held_frame", last_frame[0], exp_frame(1'b0, 16'h0F0F, 8'h00));
    $display("txn inst=0 div=1 held req frames=%0d rdata=%02h", frames[0], rdata[0]);

    run_txn(2, 1'b0, 16'($urandom), 8'h00, 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
